latch_checker: RTL

Synthesizable exerciser and checker for a level-sensitive D latch. It drives the latch enable and data inputs through a fixed 9-step pattern, holding each step for a programmable number of clock cycles. On every step it compares the latch's q and q_n outputs against an internal reference model and counts mismatches. It sits beside a latch instance on the circuitry lab board, replacing a simulation-only stimulus sequence with a hardware self-test that reports pass/fail.

---
 rtl/latch_checker_if.sv | 26 ++
 rtl/latch_checker.sv | 126 ++++++++++++
 2 files changed

// File: rtl/latch_checker_if.sv
// Signal bundle between the latch exerciser/checker and its environment:
// control/status plus the drive and observe lines of the latch under test.
interface latch_checker_if #(
  parameter int unsigned ERR_W = 4
);
  logic             start;
  logic             dut_en;
  logic             dut_d;
  logic             dut_q;
  logic             dut_q_n;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       step;

  modport master (
    output start, dut_q, dut_q_n,
    input  dut_en, dut_d, busy, done, pass, err_count, step
  );

  modport slave (
    input  start, dut_q, dut_q_n,
    output dut_en, dut_d, busy, done, pass, err_count, step
  );
endinterface

// File: rtl/latch_checker.sv
// Hardware self-test for a level-sensitive D latch: steps enable/data through a
// fixed 9-step pattern and counts steps where q/q_n disagree with a reference.
module latch_checker #(
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned ERR_W       = 4
) (
  input logic             clk,
  input logic             reset,
  latch_checker_if.slave  bus
);

  localparam int unsigned     TW        = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0]   TimerLast = TW'(STEP_CYCLES - 1);
  localparam logic [3:0]      LastStep  = 4'd8;

  // Bit k holds the enable / data value driven during step k.
  localparam logic [8:0] PatEn = 9'b001110010;
  localparam logic [8:0] PatD  = 9'b101011000;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             exp_q, exp_d;
  logic             exp_valid_q, exp_valid_d;
  logic             en_q, en_d;
  logic             d_q, d_d;

  logic             step_last;
  logic             exp_now;
  logic             valid_now;
  logic             mismatch;
  logic [3:0]       next_step;

  always_comb begin
    step_last = (timer_q == TimerLast);
    next_step = step_q + 4'd1;
    // Reference includes the current step's own drive before it is checked.
    exp_now   = PatEn[step_q] ? PatD[step_q] : exp_q;
    valid_now = exp_valid_q | PatEn[step_q];
    mismatch  = valid_now && ((bus.dut_q != exp_now) || (bus.dut_q_n == bus.dut_q));
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    timer_d     = timer_q;
    err_d       = err_q;
    exp_d       = exp_q;
    exp_valid_d = exp_valid_q;
    en_d        = en_q;
    d_d         = d_q;

    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d     = StRun;
          step_d      = 4'd0;
          timer_d     = '0;
          err_d       = '0;
          exp_d       = 1'b0;
          exp_valid_d = 1'b0;
          en_d        = PatEn[0];
          d_d         = PatD[0];
        end
      end
      StRun: begin
        if (step_last) begin
          timer_d     = '0;
          exp_d       = exp_now;
          exp_valid_d = valid_now;
          if (mismatch && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
          end
          if (step_q == LastStep) begin
            state_d = StDone;
            en_d    = 1'b0;
            d_d     = 1'b0;
          end else begin
            step_d = next_step;
            en_d   = PatEn[next_step];
            d_d    = PatD[next_step];
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      step_q      <= 4'd0;
      timer_q     <= '0;
      err_q       <= '0;
      exp_q       <= 1'b0;
      exp_valid_q <= 1'b0;
      en_q        <= 1'b0;
      d_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      exp_q       <= exp_d;
      exp_valid_q <= exp_valid_d;
      en_q        <= en_d;
      d_q         <= d_d;
    end
  end

  assign bus.dut_en    = en_q;
  assign bus.dut_d     = d_q;
  assign bus.busy      = (state_q == StRun);
  assign bus.done      = (state_q == StDone);
  assign bus.pass      = (state_q == StDone) && (err_q == '0);
  assign bus.err_count = err_q;
  assign bus.step      = step_q;

endmodule
